// File: rtl/spi_arbiter_if.sv
// Requester-side and SPI-master-side signals of the SPI arbiter.
// The arbiter uses the slave modport; the environment uses the master modport.
interface spi_arbiter_if #(
   parameter int BITS       = 28,
   parameter int REQUESTERS = 3
);
   logic [REQUESTERS-1:0]      i_req;
   logic [REQUESTERS*BITS-1:0] i_wdata;
   logic [REQUESTERS-1:0]      o_gnt;
   logic [REQUESTERS-1:0]      o_done;
   logic [BITS-1:0]            o_rdata;
   logic                       o_send;
   logic [BITS-1:0]            o_mdata;
   logic                       i_mbusy;
   logic [BITS-1:0]            i_mdata;
   logic                       i_ss;
   logic [REQUESTERS-1:0]      o_ss_n;

   modport slave (
      input  i_req, i_wdata, i_mbusy, i_mdata, i_ss,
      output o_gnt, o_done, o_rdata, o_send, o_mdata, o_ss_n
   );

   modport master (
      output i_req, i_wdata, i_mbusy, i_mdata, i_ss,
      input  o_gnt, o_done, o_rdata, o_send, o_mdata, o_ss_n
   );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among REQUESTERS ports; the
// port that owns the master also owns the slave with the same index.
module spi_arbiter #(
   parameter int BITS       = 28,
   parameter int REQUESTERS = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   spi_arbiter_if.slave  bus
);
   localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      SEND  = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                state, nxt;
   logic [PW-1:0]         rr_ptr, owner;
   logic [REQUESTERS-1:0] gnt_q;
   logic [BITS-1:0]       mdata_q, rdata_q;
   logic [2:0]            to_cnt;

   logic                  pick_vld;
   logic [PW-1:0]         pick_idx;
   logic [REQUESTERS-1:0] pick_oh;
   int                    j;

   // First requester at or above rr_ptr, wrapping around.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      pick_oh  = '0;
      j        = 0;
      for (int i = 0; i < REQUESTERS; i++) begin
         j = (int'(rr_ptr) + i) % REQUESTERS;
         if (!pick_vld && bus.i_req[j]) begin
            pick_vld   = 1'b1;
            pick_idx   = PW'(j);
            pick_oh[j] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = (|bus.i_req) ? GRANT : IDLE;
         GRANT:   nxt = pick_vld ? SEND : IDLE;
         SEND:    if (bus.i_mbusy)        nxt = WAIT;
                  else if (to_cnt == 3'd7) nxt = DONE;
                  else                     nxt = SEND;
         WAIT:    nxt = bus.i_mbusy ? WAIT : DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rr_ptr  <= '0;
         owner   <= '0;
         gnt_q   <= '0;
         mdata_q <= '0;
         rdata_q <= '0;
         to_cnt  <= '0;
      end else begin
         case (state)
            GRANT: if (pick_vld) begin
               gnt_q   <= pick_oh;
               owner   <= pick_idx;
               mdata_q <= bus.i_wdata[int'(pick_idx)*BITS +: BITS];
               to_cnt  <= '0;
            end
            SEND: if (!bus.i_mbusy) to_cnt <= to_cnt + 3'd1;
            WAIT: if (!bus.i_mbusy) rdata_q <= bus.i_mdata;
            DONE: begin
               gnt_q  <= '0;
               rr_ptr <= (owner == PW'(REQUESTERS-1)) ? '0 : owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_gnt   = gnt_q;
   assign bus.o_done  = (state == DONE) ? gnt_q : '0;
   assign bus.o_send  = (state == SEND);
   assign bus.o_mdata = mdata_q;
   assign bus.o_rdata = rdata_q;
   // Only the owner's slave sees the master's select; everyone else stays deselected.
   assign bus.o_ss_n  = ~gnt_q | {REQUESTERS{bus.i_ss}};
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a table of transfers plus hand-written
// sequences for data stability, SEND timeout and mid-transfer reset.
module tb_spi_arbiter;
   localparam int BITS = 28;
   localparam int R    = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_arbiter_if #(.BITS(BITS), .REQUESTERS(R)) bus ();
   spi_arbiter #(.BITS(BITS), .REQUESTERS(R)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   logic [BITS-1:0] w [R];
   assign bus.i_wdata = {w[2], w[1], w[0]};

   int checks = 0;
   int errors = 0;
   logic [BITS-1:0] last_rdata;

   typedef struct {
      logic [R-1:0]    req;
      logic [R-1:0]    gnt;
      logic [BITS-1:0] mdata;
      logic [BITS-1:0] echo;
   } vec_t;
   vec_t vt [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_send();
      int n;
      n = 0;
      while (!bus.o_send && n < 20) begin
         tick();
         n++;
      end
      chk("send_start", {63'd0, bus.o_send}, 64'd1);
   endtask

   task automatic do_xfer(input logic [R-1:0] egnt, input logic [BITS-1:0] emdata,
                          input logic [BITS-1:0] echo);
      logic [R-1:0] ss_exp;
      ss_exp = ~egnt;
      wait_send();
      chk("gnt", {61'd0, bus.o_gnt}, {61'd0, egnt});
      chk("mdata", {36'd0, bus.o_mdata}, {36'd0, emdata});
      chk("done_early", {61'd0, bus.o_done}, 64'd0);
      bus.i_mbusy = 1'b1;
      bus.i_mdata = ~echo;
      tick();
      chk("send_drop", {63'd0, bus.o_send}, 64'd0);
      bus.i_ss = 1'b0;
      #1 chk("ss_low", {61'd0, bus.o_ss_n}, {61'd0, ss_exp});
      bus.i_ss = 1'b1;
      #1 chk("ss_high", {61'd0, bus.o_ss_n}, 64'd7);
      tick();
      chk("done_wait", {61'd0, bus.o_done}, 64'd0);
      bus.i_mbusy = 1'b0;
      bus.i_mdata = echo;
      tick();
      chk("done", {61'd0, bus.o_done}, {61'd0, egnt});
      chk("rdata", {36'd0, bus.o_rdata}, {36'd0, echo});
      last_rdata = echo;
      tick();
      chk("done_pulse", {61'd0, bus.o_done}, 64'd0);
      chk("gnt_clr", {61'd0, bus.o_gnt}, 64'd0);
   endtask

   initial begin
      int n;
      vt[0] = '{3'b111, 3'b001, 28'h1111111, 28'h0000001};
      vt[1] = '{3'b111, 3'b010, 28'h0ABCDEF, 28'h0000002};
      vt[2] = '{3'b111, 3'b100, 28'h0FEDCBA, 28'h0000003};
      vt[3] = '{3'b111, 3'b001, 28'h1111111, 28'h0000004};
      vt[4] = '{3'b010, 3'b010, 28'h0ABCDEF, 28'h1234567};
      vt[5] = '{3'b101, 3'b100, 28'h0FEDCBA, 28'h0F0F0F0};
      vt[6] = '{3'b110, 3'b010, 28'h0ABCDEF, 28'h0A5A5A5};
      vt[7] = '{3'b011, 3'b001, 28'h1111111, 28'h7654321};
      vt[8] = '{3'b110, 3'b010, 28'h0ABCDEF, 28'h0000ABC};

      w[0] = 28'h1111111; w[1] = 28'h0ABCDEF; w[2] = 28'h0FEDCBA;
      bus.i_req = '0; bus.i_mbusy = 1'b0; bus.i_mdata = '0; bus.i_ss = 1'b1;
      last_rdata = '0;
      rst = 1'b0;
      tick();
      tick();
      chk("rst_gnt",   {61'd0, bus.o_gnt},   64'd0);
      chk("rst_done",  {61'd0, bus.o_done},  64'd0);
      chk("rst_send",  {63'd0, bus.o_send},  64'd0);
      chk("rst_mdata", {36'd0, bus.o_mdata}, 64'd0);
      chk("rst_rdata", {36'd0, bus.o_rdata}, 64'd0);
      chk("rst_ss_n",  {61'd0, bus.o_ss_n},  64'd7);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         bus.i_req = vt[i].req;
         do_xfer(vt[i].gnt, vt[i].mdata, vt[i].echo);
      end
      bus.i_req = '0;
      tick();

      // wdata changes mid-transfer and request is dropped before DONE
      w[0] = 28'h0000001;
      bus.i_req = 3'b001;
      wait_send();
      chk("stab_gnt", {61'd0, bus.o_gnt}, 64'd1);
      chk("stab_m0", {36'd0, bus.o_mdata}, 64'h1);
      bus.i_mbusy = 1'b1;
      tick();
      w[0] = 28'h0000002;
      tick();
      chk("stab_m1", {36'd0, bus.o_mdata}, 64'h1);
      tick();
      chk("stab_m2", {36'd0, bus.o_mdata}, 64'h1);
      bus.i_mbusy = 1'b0;
      bus.i_mdata = 28'h0000099;
      bus.i_req = '0;
      tick();
      chk("stab_done", {61'd0, bus.o_done}, 64'd1);
      chk("stab_m3", {36'd0, bus.o_mdata}, 64'h1);
      chk("stab_rdata", {36'd0, bus.o_rdata}, 64'h99);
      last_rdata = 28'h0000099;
      tick();
      chk("stab_pulse", {61'd0, bus.o_done}, 64'd0);

      // SEND timeout: master never goes busy
      bus.i_mdata = 28'h0BADBAD;
      bus.i_req = 3'b001;
      wait_send();
      n = 0;
      while (bus.o_send && n < 20) begin
         n++;
         tick();
      end
      chk("to_len", 64'(n), 64'd8);
      chk("to_done", {61'd0, bus.o_done}, 64'd1);
      chk("to_rdata", {36'd0, bus.o_rdata}, {36'd0, last_rdata});
      bus.i_req = '0;
      tick();
      chk("to_pulse", {61'd0, bus.o_done}, 64'd0);

      // Reset during WAIT
      bus.i_req = 3'b010;
      wait_send();
      chk("rm_gnt", {61'd0, bus.o_gnt}, 64'd2);
      bus.i_mbusy = 1'b1;
      tick();
      bus.i_ss = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rm_gnt0",  {61'd0, bus.o_gnt},   64'd0);
      chk("rm_done0", {61'd0, bus.o_done},  64'd0);
      chk("rm_send0", {63'd0, bus.o_send},  64'd0);
      chk("rm_mdata", {36'd0, bus.o_mdata}, 64'd0);
      chk("rm_rdata", {36'd0, bus.o_rdata}, 64'd0);
      chk("rm_ss_n",  {61'd0, bus.o_ss_n},  64'd7);
      bus.i_mbusy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rm_no_done", {61'd0, bus.o_done}, 64'd0);
      end
      bus.i_ss = 1'b1;
      bus.i_req = 3'b011;
      rst = 1'b1;
      do_xfer(3'b001, w[0], 28'h0000777);
      bus.i_req = 3'b100;
      do_xfer(3'b100, w[2], 28'h0C0FFEE);
      bus.i_req = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter BITS, default 28, SPI frame width in bits.
REQ-002 Parameter REQUESTERS, default 3, number of requester ports; requester k owns slave k.
REQ-003 i_clk  input  1  system clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  REQUESTERS  per-requester transfer request, level, held until o_done.
REQ-006 i_wdata  input  REQUESTERS*BITS  per-requester transmit word; slice k = bits [k*BITS +: BITS].
REQ-007 o_gnt  output  REQUESTERS  one-hot current owner; all zero when idle.
REQ-008 o_done  output  REQUESTERS  one-cycle completion pulse to the owner.
REQ-009 o_rdata  output  BITS  word received in the last completed transfer.
REQ-010 o_send  output  1  start strobe to the SPI master.
REQ-011 o_mdata  output  BITS  transmit word to the SPI master.
REQ-012 i_mbusy  input  1  SPI master busy flag.
REQ-013 i_mdata  input  BITS  SPI master received word.
REQ-014 i_ss  input  1  SPI master slave-select, active-low.
REQ-015 o_ss_n  output  REQUESTERS  per-slave select, active-low.

Function
REQ-016 FSM states: IDLE, GRANT, SEND, WAIT, DONE; registered state, combinational next-state.
REQ-017 IDLE: if any i_req bit is set, go to GRANT; otherwise stay.
REQ-018 GRANT: pick the owner by round-robin starting at pointer rr_ptr, searching upward modulo REQUESTERS; register o_gnt one-hot and latch the owner's i_wdata into o_mdata; go to SEND.
REQ-019 SEND: o_send=1; stay until i_mbusy=1 is sampled, then go to WAIT; o_send=0 in every other state.
REQ-020 SEND timeout: if i_mbusy stays 0 for 8 consecutive SEND cycles, go to DONE with o_rdata unchanged (transfer abandoned, o_done still pulsed).
REQ-021 WAIT: stay while i_mbusy=1; on i_mbusy=0, capture i_mdata into o_rdata and go to DONE.
REQ-022 DONE: o_done[owner]=1 for exactly one cycle; rr_ptr <= (owner+1) mod REQUESTERS; clear o_gnt; go to IDLE.
REQ-023 Minimum gap between two grants is 2 cycles (DONE, IDLE); a requester still holding i_req after o_done is rearbitrated normally.
REQ-024 Round-robin: a continuously requesting port is served at most REQUESTERS grants later.
REQ-025 A request dropped between GRANT and DONE does not abort the transfer; the arbiter completes and pulses o_done.
REQ-026 i_wdata changes after GRANT do not affect o_mdata for the current transfer.
REQ-027 o_ss_n[k] = i_ss when o_gnt[k]=1, else 1 (combinational); all bits 1 when idle.
REQ-028 Unused/illegal state encodings return to IDLE on the next clock.
REQ-029 o_gnt, o_done, o_send are never asserted for more than one requester.

Reset
REQ-030 While i_rst=0: state=IDLE, rr_ptr=0, o_gnt=0, o_done=0, o_send=0, o_mdata=0, o_rdata=0, timeout counter=0, o_ss_n all ones.
REQ-031 Reset mid-transfer takes effect asynchronously; no o_done pulse is produced for the aborted transfer.
REQ-032 The first arbitration after reset favours requester 0.

Verification
REQ-033 Single request: i_req=3'b010, wdata[1]=28'h0ABCDEF, master model echoes 28'h1234567 -> o_gnt=3'b010, o_mdata=28'h0ABCDEF, o_ss_n[1] follows i_ss, o_rdata=28'h1234567, o_done=3'b010 for one cycle.
REQ-034 Fairness: i_req=3'b111 held -> grant order 0,1,2,0 with one o_done per grant.
REQ-035 Timeout: i_req=3'b001, i_mbusy tied 0 -> o_send high 8 cycles, o_done[0] pulse, o_rdata unchanged.
REQ-036 Data stability: change wdata[0] from 28'h1 to 28'h2 during WAIT -> o_mdata stays 28'h1 until DONE.
REQ-037 Reset mid-transfer: assert i_rst=0 during WAIT -> all outputs at reset values immediately, no o_done; after release, i_req=3'b100 is granted normally.
